pipe_load: RTL and testbench

- Four-stage load pipeline: the read-side counterpart of the ALU/store pipeline.
- Fetches a word from the 256x16 data memory and optionally combines it with a register operand.
- Writes the result back into the 16x16 register file.
- Owns a single-port data memory, preloaded through a write port, plus a register file with a debug read port.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/alu_stage.sv | 28 ++
 rtl/pipe_load.sv | 103 ++++++++++
 tb/tb_pipe_load.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and opcodes for the load pipeline.
// Stage bundle carries one request from S1 through S3.
package pipe_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 8;
  localparam int RW_DEF = 4;

  localparam logic [3:0] FN_PASS = 4'b0000;
  localparam logic [3:0] FN_ADD  = 4'b0001;
  localparam logic [3:0] FN_SUB  = 4'b0010;
  localparam logic [3:0] FN_AND  = 4'b0011;
  localparam logic [3:0] FN_OR   = 4'b0100;

  typedef struct packed {
    logic              valid;
    logic [RW_DEF-1:0] rd;
    logic [RW_DEF-1:0] rs;
    logic [3:0]        func;
    logic [AW_DEF-1:0] addr;
  } stage_t;

endpackage

// File: rtl/alu_stage.sv
// Combine stage: mem word op register operand.
// Ports: func/mem/op in, res/err out (err on undefined func).
module alu_stage
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [3:0]    func,
  input  logic [DW-1:0] mem,
  input  logic [DW-1:0] op,
  output logic [DW-1:0] res,
  output logic          err
);

  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (1'b1)
      func == FN_PASS: res = mem;
      func == FN_ADD:  res = mem + op;
      func == FN_SUB:  res = mem - op;
      func == FN_AND:  res = mem & op;
      func == FN_OR:   res = mem | op;
      default:         err = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_load.sv
// Four-stage load pipeline: issue, mem read, combine, writeback.
// Owns 2**AW x DW data memory (preload port) and 2**RW x DW reg file.
module pipe_load
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rs,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_err,
  input  logic [RW-1:0] dbg_rs,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rf  [2**RW];

  stage_t        s1, s2, s3;
  logic [DW-1:0] s2_mem;
  logic [DW-1:0] s3_mem;
  logic [DW-1:0] s3_op;
  logic [DW-1:0] s2_op;
  logic [DW-1:0] alu_res;
  logic          alu_err;
  logic          stall;
  logic          fwd;
  logic          wr_ok;

  // Preload write owns the single memory port.
  assign stall    = s1.valid && mem_we;
  assign in_ready = !stall;

  assign wr_ok = s3.valid && !alu_err;
  assign fwd   = wr_ok && (s3.rd == s2.rs);
  assign s2_op = fwd ? alu_res : rf[s2.rs];

  assign dbg_data = rf[dbg_rs];

  alu_stage #(.DW(DW)) u_alu (
    .func (s3.func),
    .mem  (s3_mem),
    .op   (s3_op),
    .res  (alu_res),
    .err  (alu_err)
  );

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      s2_mem   <= '0;
      s3_mem   <= '0;
      s3_op    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
      for (int i = 0; i < 2**RW; i++)
        rf[i] <= '0;
    end else begin
      if (!stall) begin
        s1.valid <= in_valid;
        s1.rd    <= rd;
        s1.rs    <= rs;
        s1.func  <= func;
        s1.addr  <= addr;
        s2_mem   <= mem[s1.addr];
      end
      s2       <= s1;
      s2.valid <= s1.valid && !stall;
      s3       <= s2;
      s3_mem   <= s2_mem;
      s3_op    <= s2_op;
      wb_valid <= s3.valid;
      wb_rd    <= s3.rd;
      wb_err   <= s3.valid && alu_err;
      wb_data  <= wr_ok ? alu_res : '0;
      if (wr_ok)
        rf[s3.rd] <= alu_res;
    end
  end

endmodule

// File: tb/tb_pipe_load.sv
// Directed bench for pipe_load.
// Each task drives one scenario and checks inline.
module tb_pipe_load;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  func;
  logic [7:0]  addr;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_err;
  logic [3:0]  dbg_rs;
  logic [15:0] dbg_data;

  int pass_cnt = 0;
  int total = 0;

  pipe_load dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd        (rd),
    .rs        (rs),
    .func      (func),
    .addr      (addr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_err    (wb_err),
    .dbg_rs    (dbg_rs),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a,
                         input logic [15:0] d);
    mem_we    = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] s,
                       input logic [3:0] f, input logic [7:0] a);
    in_valid = 1'b1;
    rd       = d;
    rs       = s;
    func     = f;
    addr     = a;
  endtask

  task automatic issue(input logic [3:0] d, input logic [3:0] s,
                       input logic [3:0] f, input logic [7:0] a);
    drive(d, s, f, a);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    while (!wb_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wb_valid !== 1'b0 || wb_err !== 1'b0)
      $display("FAIL rst_wb valid=%b err=%b want 0/0",
               wb_valid, wb_err);
    else pass_cnt++;
    total++;
    if (wb_data !== 16'h0 || wb_rd !== 4'h0)
      $display("FAIL rst_wbdata data=%h rd=%h want 0/0",
               wb_data, wb_rd);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_ready got %b want 1", in_ready);
    else pass_cnt++;
    dbg_rs = 4'd9;
    #1;
    total++;
    if (dbg_data !== 16'h0)
      $display("FAIL rst_rf got %h want 0000", dbg_data);
    else pass_cnt++;
  endtask

  task automatic test_pass();
    int n;
    preload(8'h10, 16'h1234);
    drive(4'd3, 4'd0, 4'b0000, 8'h10);
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL pass_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    wait_wb(n);
    total++;
    if (n !== 3)
      $display("FAIL pass_latency got %0d want 3", n);
    else pass_cnt++;
    total++;
    if (wb_rd !== 4'd3 || wb_data !== 16'h1234 || wb_err !== 1'b0)
      $display("FAIL pass_wb rd=%h data=%h err=%b want 3/1234/0",
               wb_rd, wb_data, wb_err);
    else pass_cnt++;
    dbg_rs = 4'd3;
    #1;
    total++;
    if (dbg_data !== 16'h1234)
      $display("FAIL pass_dbg got %h want 1234", dbg_data);
    else pass_cnt++;
    tick();
    total++;
    if (wb_valid !== 1'b0)
      $display("FAIL pass_pulse got %b want 0", wb_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    preload(8'h20, 16'h0005);
    preload(8'h21, 16'h0007);
    issue(4'd1, 4'd0, 4'b0000, 8'h20);
    drive(4'd2, 4'd1, 4'b0001, 8'h21);
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    wait_wb(n);
    total++;
    if (n !== 2 || wb_rd !== 4'd1 || wb_data !== 16'h0005)
      $display("FAIL b2b_first n=%0d rd=%h data=%h want 2/1/0005",
               n, wb_rd, wb_data);
    else pass_cnt++;
    tick();
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 4'd2 || wb_data !== 16'h000C)
      $display("FAIL b2b_fwd v=%b rd=%h data=%h want 1/2/000C",
               wb_valid, wb_rd, wb_data);
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int n;
    preload(8'h40, 16'h0003);
    issue(4'd4, 4'd0, 4'b0000, 8'h40);
    wait_wb(n);
    tick();
    preload(8'h30, 16'h0001);
    issue(4'd6, 4'd4, 4'b0010, 8'h30);
    wait_wb(n);
    total++;
    if (n !== 3 || wb_rd !== 4'd6 || wb_data !== 16'hFFFE)
      $display("FAIL sub_wrap n=%0d rd=%h data=%h want 3/6/FFFE",
               n, wb_rd, wb_data);
    else pass_cnt++;
  endtask

  task automatic test_logic();
    int n;
    issue(4'd7, 4'd3, 4'b0011, 8'h21);
    wait_wb(n);
    total++;
    if (wb_data !== 16'h0004)
      $display("FAIL and_op got %h want 0004", wb_data);
    else pass_cnt++;
    issue(4'd8, 4'd3, 4'b0100, 8'h21);
    wait_wb(n);
    total++;
    if (wb_data !== 16'h1237)
      $display("FAIL or_op got %h want 1237", wb_data);
    else pass_cnt++;
    tick();
    issue(4'd3, 4'd3, 4'b0001, 8'h21);
    wait_wb(n);
    total++;
    if (wb_data !== 16'h123B)
      $display("FAIL rd_eq_rs got %h want 123B", wb_data);
    else pass_cnt++;
  endtask

  task automatic test_mem_stall();
    int n;
    preload(8'h50, 16'h1111);
    issue(4'd9, 4'd0, 4'b0000, 8'h50);
    mem_we    = 1'b1;
    mem_waddr = 8'h50;
    mem_wdata = 16'hBEEF;
    #1;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL stall_ready1 got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL stall_ready2 got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    mem_we = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL stall_release got %b want 1", in_ready);
    else pass_cnt++;
    wait_wb(n);
    total++;
    if (n + 2 !== 5)
      $display("FAIL stall_latency got %0d want 5", n + 2);
    else pass_cnt++;
    total++;
    if (wb_rd !== 4'd9 || wb_data !== 16'hBEEF)
      $display("FAIL stall_data rd=%h data=%h want 9/BEEF",
               wb_rd, wb_data);
    else pass_cnt++;
  endtask

  task automatic test_err();
    int n;
    preload(8'h60, 16'h5555);
    issue(4'd5, 4'd0, 4'b0000, 8'h60);
    wait_wb(n);
    issue(4'd5, 4'd0, 4'b0111, 8'h60);
    wait_wb(n);
    total++;
    if (n !== 3 || wb_valid !== 1'b1)
      $display("FAIL err_valid n=%0d v=%b want 3/1", n, wb_valid);
    else pass_cnt++;
    total++;
    if (wb_err !== 1'b1 || wb_data !== 16'h0 || wb_rd !== 4'd5)
      $display("FAIL err_wb err=%b data=%h rd=%h want 1/0000/5",
               wb_err, wb_data, wb_rd);
    else pass_cnt++;
    tick();
    dbg_rs = 4'd5;
    #1;
    total++;
    if (dbg_data !== 16'h5555)
      $display("FAIL err_nowrite got %h want 5555", dbg_data);
    else pass_cnt++;
    total++;
    if (wb_valid !== 1'b0 || wb_err !== 1'b0)
      $display("FAIL err_pulse v=%b err=%b want 0/0",
               wb_valid, wb_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_flight();
    int seen;
    int bad;
    logic [15:0] bad_val;
    issue(4'd10, 4'd0, 4'b0000, 8'h10);
    issue(4'd11, 4'd0, 4'b0000, 8'h20);
    issue(4'd12, 4'd0, 4'b0000, 8'h21);
    issue(4'd13, 4'd0, 4'b0000, 8'h30);
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h1234)
      $display("FAIL flight_pre v=%b data=%h want 1/1234",
               wb_valid, wb_data);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (wb_valid !== 1'b0 || wb_data !== 16'h0 || wb_rd !== 4'h0)
      $display("FAIL flight_async v=%b data=%h rd=%h want 0",
               wb_valid, wb_data, wb_rd);
    else pass_cnt++;
    tick();
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wb_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0)
      $display("FAIL flight_nowb got %0d pulses want 0", seen);
    else pass_cnt++;
    bad = -1;
    bad_val = '0;
    for (int i = 0; i < 16; i++) begin
      dbg_rs = i[3:0];
      #1;
      if (dbg_data !== 16'h0 && bad < 0) begin
        bad = i;
        bad_val = dbg_data;
      end
    end
    total++;
    if (bad >= 0)
      $display("FAIL flight_rf reg%0d got %h want 0000",
               bad, bad_val);
    else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    rd        = '0;
    rs        = '0;
    func      = '0;
    addr      = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    dbg_rs    = '0;
    test_reset();
    test_pass();
    test_back_to_back();
    test_sub();
    test_logic();
    test_mem_stall();
    test_err();
    test_reset_flight();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
